// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the nibble multiplier sequencer.
// The default LATENCY here is also used by the multiplier wrapper, so both sides agree.
package mul_seq_pkg;

    localparam int NIB_W       = 4;
    localparam int PROD_W      = 8;
    localparam int MUL_LATENCY = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        RUN    = 3'd3,
        RD_LO  = 3'd4,
        RD_HI  = 3'd5,
        DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/mul_sign_fix.sv
// Combinational sign handling for the sequencer's signed mode.
// Converts negative nibbles to their 4-bit magnitude and conditionally negates the 8-bit
// product. -8 maps to 4'b1000, which is a valid unsigned magnitude for the multiplier.
module mul_sign_fix
    import mul_seq_pkg::*;
(
    input  logic              en,
    input  logic [NIB_W-1:0]  op_a,
    input  logic [NIB_W-1:0]  op_b,
    output logic [NIB_W-1:0]  mag_a,
    output logic [NIB_W-1:0]  mag_b,
    output logic              neg,
    input  logic              prod_neg,
    input  logic [PROD_W-1:0] prod_in,
    output logic [PROD_W-1:0] prod_out
);

    assign mag_a    = (en && op_a[NIB_W-1]) ? -op_a : op_a;
    assign mag_b    = (en && op_b[NIB_W-1]) ? -op_b : op_b;
    assign neg      = en & (op_a[NIB_W-1] ^ op_b[NIB_W-1]);
    assign prod_out = prod_neg ? -prod_in : prod_in;

endmodule

// File: rtl/mul_sequencer.sv
// Control stage in front of the serial nibble multiplier: loads both operands, waits out
// the shift-add run, reads the product back nibble by nibble and hands it off over
// PVALID/PREADY. All outputs come from registers or a decode of the state register.
// Optional build macro MUL_SEQ_SIGNED_EN adds two's-complement operand support
// (magnitude loading plus product negate) without adding cycles.
module mul_sequencer
    import mul_seq_pkg::*;
#(
    parameter int LATENCY = MUL_LATENCY
) (
    input  logic              MUL_CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              SIGNED,
    input  logic [NIB_W-1:0]  OP_A,
    input  logic [NIB_W-1:0]  OP_B,
    output logic              BUSY,
    output logic [NIB_W-1:0]  M_DIN,
    output logic              M_LOAD,
    output logic              M_RSEL,
    input  logic [NIB_W-1:0]  M_R,
    output logic [PROD_W-1:0] PROD,
    output logic              PVALID,
    input  logic              PREADY
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state_q, state_d;
    logic [NIB_W-1:0]   a_q, a_d;
    logic [NIB_W-1:0]   b_q, b_d;
    logic [NIB_W-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PROD_W-1:0]  prod_q, prod_d;
    logic               pvalid_q, pvalid_d;

    logic [NIB_W-1:0]   cap_a, cap_b;
    logic [PROD_W-1:0]  prod_fix;

`ifdef MUL_SEQ_SIGNED_EN
    logic cap_neg;
    logic neg_q, neg_d;

    mul_sign_fix u_sign_fix (
        .en       (SIGNED),
        .op_a     (OP_A),
        .op_b     (OP_B),
        .mag_a    (cap_a),
        .mag_b    (cap_b),
        .neg      (cap_neg),
        .prod_neg (neg_q),
        .prod_in  ({M_R, lo_q}),
        .prod_out (prod_fix)
    );

    // Product sign is captured alongside the operands when a request is accepted
    always_comb begin
        neg_d = neg_q;
        if (state_q == IDLE && START) neg_d = cap_neg;
    end

    // Sign register
    always_ff @(posedge MUL_CLK or negedge RST_N) begin
        if (!RST_N) neg_q <= 1'b0;
        else        neg_q <= neg_d;
    end
`else
    logic unused_signed;

    assign unused_signed = SIGNED;
    assign cap_a         = OP_A;
    assign cap_b         = OP_B;
    assign prod_fix      = {M_R, lo_q};
`endif

    // Next-state, counter, readback and handshake logic
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        lo_d     = lo_q;
        count_d  = count_q;
        prod_d   = prod_q;
        pvalid_d = pvalid_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    a_d     = cap_a;
                    b_d     = cap_b;
                    state_d = LOAD_A;
                end
            end
            LOAD_A: state_d = LOAD_B;
            LOAD_B: begin
                count_d = CNT_W'(LATENCY - 1);
                state_d = RUN;
            end
            RUN: begin
                if (count_q == '0) state_d = RD_LO;
                else               count_d = count_q - 1'b1;
            end
            RD_LO: begin
                lo_d    = M_R;
                state_d = RD_HI;
            end
            RD_HI: begin
                prod_d   = prod_fix;
                pvalid_d = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                if (PREADY) begin
                    pvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge MUL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            lo_q     <= '0;
            count_q  <= '0;
            prod_q   <= '0;
            pvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            lo_q     <= lo_d;
            count_q  <= count_d;
            prod_q   <= prod_d;
            pvalid_q <= pvalid_d;
        end
    end

    // Multiplier controls decoded from the state register only
    always_comb begin
        M_LOAD = (state_q == LOAD_A) || (state_q == LOAD_B);
        M_RSEL = (state_q == LOAD_B) || (state_q == RD_HI);
        M_DIN  = '0;
        if (state_q == LOAD_A) M_DIN = a_q;
        if (state_q == LOAD_B) M_DIN = b_q;
    end

    assign BUSY   = (state_q != IDLE);
    assign PROD   = prod_q;
    assign PVALID = pvalid_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer with a behavioural model of the serial nibble multiplier.
// Products are queued when a request is driven and compared on each PVALID/PREADY handshake.
module tb_mul_sequencer;
    import mul_seq_pkg::*;

    localparam int LAT = 4;

    logic              MUL_CLK = 1'b0;
    logic              RST_N   = 1'b1;
    logic              START   = 1'b0;
    logic              SIGNED  = 1'b0;
    logic [NIB_W-1:0]  OP_A    = '0;
    logic [NIB_W-1:0]  OP_B    = '0;
    logic              BUSY;
    logic [NIB_W-1:0]  M_DIN;
    logic              M_LOAD;
    logic              M_RSEL;
    logic [NIB_W-1:0]  M_R;
    logic [PROD_W-1:0] PROD;
    logic              PVALID;
    logic              PREADY  = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int load_cnt = 0;
    logic [7:0] sb[$];

    mul_sequencer #(.LATENCY(LAT)) dut (
        .MUL_CLK (MUL_CLK),
        .RST_N   (RST_N),
        .START   (START),
        .SIGNED  (SIGNED),
        .OP_A    (OP_A),
        .OP_B    (OP_B),
        .BUSY    (BUSY),
        .M_DIN   (M_DIN),
        .M_LOAD  (M_LOAD),
        .M_RSEL  (M_RSEL),
        .M_R     (M_R),
        .PROD    (PROD),
        .PVALID  (PVALID),
        .PREADY  (PREADY)
    );

    always #5 MUL_CLK = ~MUL_CLK;

    // Serial shift-add multiplier model: LOAD+RSEL=0 loads A and clears the accumulator,
    // LOAD+RSEL=1 loads B and presets the counter; it has no reset of its own.
    logic [3:0] m_a   = '0;
    logic [7:0] m_b   = '0;
    logic [7:0] m_acc = '0;
    int         m_cnt = 0;

    always @(posedge MUL_CLK) begin
        if (M_LOAD && !M_RSEL) begin
            m_a   <= M_DIN;
            m_acc <= '0;
        end else if (M_LOAD && M_RSEL) begin
            m_b   <= {4'b0, M_DIN};
            m_cnt <= LAT;
        end else if (m_cnt != 0) begin
            if (m_a[0]) m_acc <= m_acc + m_b;
            m_a   <= m_a >> 1;
            m_b   <= m_b << 1;
            m_cnt <= m_cnt - 1;
        end
    end

    assign M_R = M_RSEL ? m_acc[7:4] : m_acc[3:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge MUL_CLK) begin
        if (M_LOAD) load_cnt <= load_cnt + 1;
    end

    // Scoreboard: one pop per handshake
    always @(negedge MUL_CLK) begin
        if (RST_N && PVALID && PREADY) begin
            if (sb.size() == 0) check("sb_unexpected", 1, 0);
            else                check("prod", {24'b0, PROD}, {24'b0, sb.pop_front()});
        end
    end

    task automatic tick();
        @(posedge MUL_CLK);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            tick();
            if (!BUSY) done = 1'b1;
        end
        check(tag, done, 1);
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic s,
                         input logic [7:0] exp);
        sb.push_back(exp);
        OP_A = a; OP_B = b; SIGNED = s; START = 1'b1;
        tick();
        START = 1'b0; OP_A = '0; OP_B = '0; SIGNED = 1'b0;
        wait_idle("op_done");
    endtask

    initial begin
        int l0;
        bit seen;
        #1 RST_N = 1'b0;
        #2;
        check("rst_busy",   BUSY,   0);
        check("rst_mload",  M_LOAD, 0);
        check("rst_mrsel",  M_RSEL, 0);
        check("rst_mdin",   M_DIN,  0);
        check("rst_prod",   PROD,   0);
        check("rst_pvalid", PVALID, 0);
        repeat (2) tick();
        RST_N = 1'b1;
        tick();

        // Basic op with exact timing: START sampled at edge 0
        sb.push_back(8'h0F);
        OP_A = 4'd3; OP_B = 4'd5; START = 1'b1;
        tick();
        START = 1'b0;
        check("busy_e0", BUSY, 1);
        repeat (7) tick();
        check("pvalid_e7", PVALID, 0);
        tick();
        check("pvalid_e8", PVALID, 1);
        check("prod_e8",   PROD,   8'h0F);
        tick();
        check("busy_e9",   BUSY,   0);
        check("pvalid_e9", PVALID, 0);

        // Extremes
        do_op(4'd15, 4'd15, 1'b0, 8'hE1);
        do_op(4'd0,  4'd9,  1'b0, 8'h00);

        // START during RUN is ignored
        l0 = load_cnt;
        sb.push_back(8'h2A);
        OP_A = 4'd6; OP_B = 4'd7; START = 1'b1;
        tick();
        START = 1'b0;
        repeat (3) tick();
        OP_A = 4'd1; OP_B = 4'd1; START = 1'b1;
        tick();
        START = 1'b0;
        wait_idle("run_ignore_done");
        repeat (3) tick();
        check("ignored_no_start", BUSY, 0);
        check("mload_pulses", load_cnt - l0, 2);

        // Back-pressure: PREADY low holds PROD/PVALID; START in DONE ignored
        PREADY = 1'b0;
        sb.push_back(8'h51);
        OP_A = 4'd9; OP_B = 4'd9; START = 1'b1;
        tick();
        START = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            tick();
            if (PVALID) seen = 1'b1;
        end
        check("bp_pvalid_seen", seen, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_pvalid", PVALID, 1);
            check("bp_prod",   PROD,   8'h51);
            START = (i == 2);
            OP_A = 4'd1; OP_B = 4'd2;
            tick();
        end
        START = 1'b0;
        PREADY = 1'b1;
        tick();
        check("bp_release_busy",   BUSY,   0);
        check("bp_release_pvalid", PVALID, 0);
        check("bp_prod_kept",      PROD,   8'h51);
        tick();
        check("done_start_ignored", BUSY, 0);

        // Reset during RUN aborts immediately
        OP_A = 4'd5; OP_B = 4'd5; START = 1'b1;
        tick();
        START = 1'b0;
        repeat (4) tick();
        check("pre_abort_busy", BUSY, 1);
        RST_N = 1'b0;
        #1;
        check("abort_busy",   BUSY,   0);
        check("abort_mload",  M_LOAD, 0);
        check("abort_pvalid", PVALID, 0);
        tick();
        RST_N = 1'b1;
        tick();
        do_op(4'd2, 4'd7, 1'b0, 8'h0E);

        // Signed stimulus; result depends on build
`ifdef MUL_SEQ_SIGNED_EN
        do_op(4'hD, 4'd5, 1'b1, 8'hF1);
`else
        do_op(4'hD, 4'd5, 1'b1, 8'h41);
`endif
        do_op(4'h8, 4'h8, 1'b1, 8'h40);

        repeat (2) tick();
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
